// File: rtl/cmd_issuer_pkg.sv
// Shared types for the command issue stage: command/scoreboard records,
// processor-count helpers and the issue FSM state encoding.
package cmd_issuer_pkg;

  localparam int unsigned PROC_COUNT = 4;
  localparam int unsigned PROC_IDX_W = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;
  localparam int unsigned CMD_ID_W   = 8;
  localparam int unsigned OPCODE_W   = 4;

  typedef logic [PROC_COUNT-1:0] proc_mask_t;
  typedef logic [PROC_IDX_W-1:0] proc_idx_t;

  typedef struct packed {
    logic [CMD_ID_W-1:0] cmd_id;
    logic [CMD_ID_W-1:0] dep_id;
    logic                has_dep;
    logic [OPCODE_W-1:0] opcode;
  } cmd_t;

  typedef struct packed {
    logic [CMD_ID_W-1:0] cmd_id;
    proc_idx_t           proc_id;
  } entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEP_REQ,
    ST_DEP_WAIT,
    ST_GAP,
    ST_ALLOC,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DISPATCH,
    ST_FL_REQ,
    ST_FL_WAIT
  } state_t;

endpackage

// File: rtl/cmd_issuer_proc_alloc.sv
// Lowest-index set-bit finder with one-hot decode; used for free-processor
// selection and for done-latch service order.
module proc_alloc
  import cmd_issuer_pkg::*;
(
  input  proc_mask_t req,
  output logic       found,
  output proc_idx_t  idx,
  output proc_mask_t onehot
);

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int unsigned i = PROC_COUNT; i > 0; i--) begin
      if (req[i-1]) begin
        found = 1'b1;
        idx   = proc_idx_t'(i - 1);
      end
    end
    if (found) onehot = proc_mask_t'(1) << idx;
  end

endmodule

// File: rtl/cmd_issuer.sv
// Issue stage: dependency wait, processor allocation, scoreboard insert and
// completion flush. Optional macro: CMD_ISSUER_DEP_CHECK_EN enables dependency lookups.
module cmd_issuer
  import cmd_issuer_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16,
  parameter int unsigned RETRY_GAP   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  cmd_t                   i_cmd,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  output proc_mask_t             o_proc_valid,
  output cmd_t                   o_proc_cmd,
  input  proc_mask_t             i_proc_done,
  output entry_t                 o_sb_entry,
  output logic                   o_sb_write,
  output logic                   o_sb_read,
  output logic                   o_sb_flush_val,
  input  logic                   i_sb_ack,
  input  logic                   i_sb_exists,
  output proc_mask_t             o_busy_mask,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

`ifdef CMD_ISSUER_DEP_CHECK_EN
  localparam bit DEP_EN = 1'b1;
`else
  localparam bit DEP_EN = 1'b0;
`endif

  localparam int unsigned GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  state_t                 state;
  cmd_t                   held;
  logic                   held_valid;
  logic                   started;
  proc_mask_t             busy;
  proc_mask_t             done_latch;
  proc_mask_t             alloc_onehot;
  proc_mask_t             flush_onehot;
  logic [GAP_W-1:0]       gap_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic       free_found, pend_found, accept, flush_ack, gap_done;
  proc_idx_t  free_idx, pend_idx;
  proc_mask_t free_onehot, pend_onehot, latch_set, latch_clr;
  cmd_t       issue_cmd;

  proc_alloc u_free (
    .req    (~busy),
    .found  (free_found),
    .idx    (free_idx),
    .onehot (free_onehot)
  );

  proc_alloc u_pend (
    .req    (done_latch),
    .found  (pend_found),
    .idx    (pend_idx),
    .onehot (pend_onehot)
  );

  assign o_cmd_ready = started && (state == ST_IDLE) && !held_valid && (done_latch == '0);
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign issue_cmd   = held_valid ? held : i_cmd;
  assign flush_ack   = (state == ST_FL_WAIT) && i_sb_ack;
  assign gap_done    = (32'(gap_cnt) + 32'd1) >= RETRY_GAP;
  // A completion counts if the processor is busy or is being dispatched right now.
  assign latch_set   = i_proc_done & (busy | o_proc_valid);
  assign latch_clr   = flush_ack ? flush_onehot : '0;
  assign o_busy_mask = busy;
  assign o_stall_cnt = stall_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state          <= ST_IDLE;
      held           <= '0;
      held_valid     <= 1'b0;
      started        <= 1'b0;
      busy           <= '0;
      done_latch     <= '0;
      alloc_onehot   <= '0;
      flush_onehot   <= '0;
      gap_cnt        <= '0;
      stall_cnt      <= '0;
      o_proc_valid   <= '0;
      o_proc_cmd     <= '0;
      o_sb_entry     <= '0;
      o_sb_write     <= 1'b0;
      o_sb_read      <= 1'b0;
      o_sb_flush_val <= 1'b0;
    end else begin
      started        <= 1'b1;
      o_proc_valid   <= '0;
      o_sb_write     <= 1'b0;
      o_sb_read      <= 1'b0;
      o_sb_flush_val <= 1'b0;
      done_latch     <= (done_latch | latch_set) & ~latch_clr;

      case (state)
        ST_IDLE: begin
          if (pend_found) begin
            state          <= ST_FL_REQ;
            flush_onehot   <= pend_onehot;
            o_sb_entry     <= '{cmd_id: '0, proc_id: pend_idx};
            o_sb_flush_val <= 1'b1;
          end else if (held_valid || accept) begin
            if (accept) begin
              held       <= i_cmd;
              held_valid <= 1'b1;
            end
            if (DEP_EN && issue_cmd.has_dep) begin
              state      <= ST_DEP_REQ;
              o_sb_entry <= '{cmd_id: issue_cmd.dep_id, proc_id: '0};
              o_sb_read  <= 1'b1;
            end else begin
              state <= ST_ALLOC;
            end
          end
        end
        ST_DEP_REQ: state <= ST_DEP_WAIT;
        ST_DEP_WAIT: begin
          if (i_sb_ack) begin
            if (i_sb_exists) begin
              if (DEP_EN && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              state <= ST_ALLOC;
            end
          end
        end
        ST_GAP: begin
          if (gap_done) state <= ST_IDLE;
          else          gap_cnt <= gap_cnt + 1'b1;
        end
        ST_ALLOC: begin
          if (free_found) begin
            alloc_onehot <= free_onehot;
            o_sb_entry   <= '{cmd_id: held.cmd_id, proc_id: free_idx};
            o_sb_write   <= 1'b1;
            state        <= ST_WR_REQ;
          end else if (pend_found) begin
            state <= ST_IDLE;
          end
        end
        ST_WR_REQ: state <= ST_WR_WAIT;
        ST_WR_WAIT: begin
          if (i_sb_ack) begin
            o_proc_valid <= alloc_onehot;
            o_proc_cmd   <= held;
            state        <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          busy       <= busy | alloc_onehot;
          held_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_FL_REQ: state <= ST_FL_WAIT;
        ST_FL_WAIT: begin
          if (i_sb_ack) begin
            busy  <= busy & ~flush_onehot;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: table-driven dispatch vectors plus
// hand-written completion, dependency and reset sequences.
module tb_cmd_issuer;
  import cmd_issuer_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  cmd_t       i_cmd = '0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  proc_mask_t o_proc_valid;
  cmd_t       o_proc_cmd;
  proc_mask_t i_proc_done = '0;
  entry_t     o_sb_entry;
  logic       o_sb_write, o_sb_read, o_sb_flush_val;
  logic       i_sb_ack = 1'b0;
  logic       i_sb_exists = 1'b0;
  proc_mask_t o_busy_mask;
  logic [15:0] o_stall_cnt;

  always #5 i_clk = ~i_clk;

  cmd_issuer #(.STALL_CNT_W(16), .RETRY_GAP(2)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .o_proc_valid(o_proc_valid), .o_proc_cmd(o_proc_cmd),
    .i_proc_done(i_proc_done), .o_sb_entry(o_sb_entry), .o_sb_write(o_sb_write),
    .o_sb_read(o_sb_read), .o_sb_flush_val(o_sb_flush_val), .i_sb_ack(i_sb_ack),
    .i_sb_exists(i_sb_exists), .o_busy_mask(o_busy_mask), .o_stall_cnt(o_stall_cnt)
  );

  typedef struct { cmd_t cmd; int proc; } disp_t;
  typedef struct { cmd_t cmd; int proc; proc_mask_t busy; } vec_t;

  int nvec = 0, nmis = 0;
  int cyc = 0;
  int sb_lat = 1;
  int flush_seen = 0, read_seen = 0;
  int last_accept = 0, last_disp = 0;
  disp_t disp_q[$];
  int    flush_q[$];
  logic [7:0] sb_cmd[PROC_COUNT];
  bit         sb_vld[PROC_COUNT];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard responder: acks each request sb_lat cycles later and keeps a
  // per-processor table of in-flight command ids for lookups.
  initial begin
    int   cnt;
    logic hit;
    cnt = 0;
    hit = 1'b0;
    forever begin
      @(negedge i_clk);
      i_sb_ack = 1'b0;
      i_sb_exists = 1'b0;
      if (!i_rstn) begin
        cnt = 0;
        for (int i = 0; i < PROC_COUNT; i++) sb_vld[i] = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            i_sb_ack = 1'b1;
            i_sb_exists = hit;
          end
        end
        if (o_sb_write || o_sb_read || o_sb_flush_val) begin
          check("sb_one_req", $onehot({o_sb_write, o_sb_read, o_sb_flush_val}), 1);
          check("sb_req_after_ack", cnt, 0);
          hit = 1'b0;
          if (o_sb_write) begin
            check("sb_write_expected", disp_q.size() > 0, 1);
            if (disp_q.size() > 0) begin
              check("sb_write_cmd", o_sb_entry.cmd_id, disp_q[0].cmd.cmd_id);
              check("sb_write_proc", o_sb_entry.proc_id, disp_q[0].proc);
            end
            sb_cmd[o_sb_entry.proc_id] = o_sb_entry.cmd_id;
            sb_vld[o_sb_entry.proc_id] = 1'b1;
          end
          if (o_sb_read) begin
            read_seen++;
            for (int i = 0; i < PROC_COUNT; i++)
              if (sb_vld[i] && sb_cmd[i] == o_sb_entry.cmd_id) hit = 1'b1;
          end
          if (o_sb_flush_val) begin
            flush_seen++;
            check("sb_flush_expected", flush_q.size() > 0, 1);
            if (flush_q.size() > 0) check("sb_flush_proc", o_sb_entry.proc_id, flush_q.pop_front());
            check("sb_flush_cmd_zero", o_sb_entry.cmd_id, 0);
            sb_vld[o_sb_entry.proc_id] = 1'b0;
          end
          cnt = sb_lat;
        end
      end
    end
  end

  // Dispatch monitor: pops the expected dispatch queue.
  initial begin
    disp_t d;
    forever begin
      @(negedge i_clk);
      if (i_rstn && o_proc_valid != '0) begin
        last_disp = cyc;
        check("disp_expected", disp_q.size() > 0, 1);
        if (disp_q.size() > 0) begin
          d = disp_q.pop_front();
          check("disp_strobe", o_proc_valid, 32'(proc_mask_t'(1) << d.proc));
          check("disp_cmd", o_proc_cmd, d.cmd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send(input cmd_t c);
    int t;
    t = 0;
    i_cmd = c;
    i_cmd_valid = 1'b1;
    while (!o_cmd_ready && t < 200) begin
      tick(1);
      t++;
    end
    check("send_ready", o_cmd_ready, 1);
    last_accept = cyc;
    tick(1);
    i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((disp_q.size() > 0 || flush_q.size() > 0 || !o_cmd_ready) && t < 300) begin
      tick(1);
      t++;
    end
    check("drain_ready", o_cmd_ready, 1);
    check("drain_queues", disp_q.size() + flush_q.size(), 0);
  endtask

  task automatic pulse_done(input proc_mask_t m);
    i_proc_done = m;
    tick(1);
    i_proc_done = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", o_cmd_ready, 0);
    check("rst_proc_valid", o_proc_valid, 0);
    check("rst_proc_cmd", o_proc_cmd, 0);
    check("rst_sb_entry", o_sb_entry, 0);
    check("rst_sb_write", o_sb_write, 0);
    check("rst_sb_read", o_sb_read, 0);
    check("rst_sb_flush", o_sb_flush_val, 0);
    check("rst_busy", o_busy_mask, 0);
    check("rst_stall", o_stall_cnt, 0);
  endtask

  function automatic cmd_t mk(input int id, input int dep, input bit has, input int op);
    cmd_t c;
    c.cmd_id = 8'(id);
    c.dep_id = 8'(dep);
    c.has_dep = has;
    c.opcode = 4'(op);
    return c;
  endfunction

  initial begin
    vec_t vt[4];
    cmd_t c;
    int   fs, t;
    logic [15:0] st;

    vt[0] = '{mk(5, 0, 0, 1), 0, 4'b0001};
    vt[1] = '{mk(6, 0, 0, 2), 1, 4'b0011};
    vt[2] = '{mk(7, 0, 0, 3), 2, 4'b0111};
    vt[3] = '{mk(8, 0, 0, 4), 3, 4'b1111};

    tick(3);
    check_reset_outputs();
    i_rstn = 1'b1;
    check("ready_at_release", o_cmd_ready, 0);
    tick(1);
    check("ready_after_release", o_cmd_ready, 1);

    for (int i = 0; i < 4; i++) begin
      disp_q.push_back('{vt[i].cmd, vt[i].proc});
      send(vt[i].cmd);
      drain();
      check("vec_busy", o_busy_mask, vt[i].busy);
      check("vec_latency", last_disp - last_accept, 3 + sb_lat);
    end

    // All processors busy: the fifth command waits for a completion.
    c = mk(9, 0, 0, 5);
    send(c);
    tick(10);
    check("allbusy_busy", o_busy_mask, 4'b1111);
    check("allbusy_ready", o_cmd_ready, 0);
    disp_q.push_back('{c, 2});
    flush_q.push_back(2);
    pulse_done(4'b0100);
    drain();
    check("allbusy_refill", o_busy_mask, 4'b1111);

    // Simultaneous completions, lowest index serviced first, no accept meanwhile.
    flush_q.push_back(0);
    flush_q.push_back(2);
    pulse_done(4'b0101);
    t = 0;
    while (flush_q.size() > 0 && t < 50) begin
      check("multi_done_ready", o_cmd_ready, 0);
      tick(1);
      t++;
    end
    drain();
    check("multi_done_busy_a", o_busy_mask, 4'b1010);
    flush_q.push_back(1);
    flush_q.push_back(3);
    pulse_done(4'b1010);
    t = 0;
    while (flush_q.size() > 0 && t < 50) begin
      check("multi_done_ready", o_cmd_ready, 0);
      tick(1);
      t++;
    end
    drain();
    check("multi_done_busy_b", o_busy_mask, 4'b0000);

    // Completion on an idle processor is ignored.
    fs = flush_seen;
    pulse_done(4'b0010);
    tick(8);
    check("spurious_flush", flush_seen, fs);
    check("spurious_busy", o_busy_mask, 0);
    check("spurious_ready", o_cmd_ready, 1);

    c = mk(3, 0, 0, 6);
    disp_q.push_back('{c, 0});
    send(c);
    drain();
    check("dep_base_busy", o_busy_mask, 4'b0001);
`ifdef CMD_ISSUER_DEP_CHECK_EN
    c = mk(7, 3, 1, 7);
    send(c);
    tick(30);
    check("dep_held_busy", o_busy_mask, 4'b0001);
    st = o_stall_cnt;
    check("dep_stalled", st >= 2, 1);
    tick(8);
    check("dep_stall_grows", o_stall_cnt > st, 1);
    flush_q.push_back(0);
    disp_q.push_back('{c, 0});
    pulse_done(4'b0001);
    drain();
    check("dep_redispatch_busy", o_busy_mask, 4'b0001);
    st = o_stall_cnt;
    tick(5);
    check("dep_stall_steady", o_stall_cnt, st);
    flush_q.push_back(0);
    pulse_done(4'b0001);
    drain();
`else
    c = mk(7, 3, 1, 7);
    disp_q.push_back('{c, 1});
    send(c);
    drain();
    check("nodep_busy", o_busy_mask, 4'b0011);
    check("nodep_stall", o_stall_cnt, 0);
    check("nodep_reads", read_seen, 0);
    flush_q.push_back(0);
    flush_q.push_back(1);
    pulse_done(4'b0011);
    drain();
`endif
    check("dep_cleanup_busy", o_busy_mask, 0);

    // Reset while the insert handshake is outstanding.
    sb_lat = 4;
    c = mk(11, 0, 0, 8);
    disp_q.push_back('{c, 0});
    send(c);
    t = 0;
    while (!o_sb_write && t < 50) begin
      tick(1);
      t++;
    end
    check("rst_saw_write", o_sb_write, 1);
    tick(1);
    i_rstn = 1'b0;
    #1;
    check_reset_outputs();
    disp_q.delete();
    tick(2);
    i_rstn = 1'b1;
    check("rst_ready_at_release", o_cmd_ready, 0);
    tick(1);
    check("rst_ready_after", o_cmd_ready, 1);
    sb_lat = 1;
    tick(10);
    check("rst_dropped_busy", o_busy_mask, 0);
    check("rst_dropped_ready", o_cmd_ready, 1);

    c = mk(12, 0, 0, 9);
    disp_q.push_back('{c, 0});
    send(c);
    drain();
    check("post_rst_busy", o_busy_mask, 4'b0001);
    check("post_rst_latency", last_disp - last_accept, 3 + sb_lat);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
